// File: rtl/csa_pkg.sv
// Shared constants, helpers and beat type for the pipelined carry-select adder.
// Optional subtract support is enabled with CSA_PIPE_SUB_EN (see csa_pipe).
package csa_pkg;

  localparam int CSA_WIDTH     = 32;
  localparam int CSA_SEG       = 8;
  localparam int CSA_STAGES    = 2;
  localparam int N_SEG         = CSA_WIDTH / CSA_SEG;
  localparam int SEG_PER_STAGE = N_SEG / CSA_STAGES;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // One pipeline beat at the default width: skewed operands, partial sum, carry.
  typedef struct packed {
    logic                 valid;
    logic [CSA_WIDTH-1:0] a;
    logic [CSA_WIDTH-1:0] b;
    logic [CSA_WIDTH-1:0] sum;
    logic                 carry;
  } beat_t;

endpackage

// File: rtl/csa_pipe_if.sv
// Valid/ready operand and result channels of csa_pipe.
// op_sub exists only when CSA_PIPE_SUB_EN is defined.
interface csa_pipe_if import csa_pkg::*; #(
  parameter int WIDTH = CSA_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
`ifdef CSA_PIPE_SUB_EN
  logic             op_sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in,
`ifdef CSA_PIPE_SUB_EN
    output op_sub,
`endif
    output out_ready,
    input  in_ready, out_valid, s, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in,
`ifdef CSA_PIPE_SUB_EN
    input  op_sub,
`endif
    input  out_ready,
    output in_ready, out_valid, s, c_out, ovf
  );
endinterface

// File: rtl/csa_seg.sv
// One carry-select segment: two ripple adds (carry 0 / carry 1) and a select mux.
module csa_seg import csa_pkg::*; #(
  parameter int SEG = CSA_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);
  logic [SEG:0] r0;
  logic [SEG:0] r1;

  assign r0   = {1'b0, a} + {1'b0, b};
  assign r1   = {1'b0, a} + {1'b0, b} + (SEG+1)'(1);
  assign sum  = cin ? r1[SEG-1:0] : r0[SEG-1:0];
  assign cout = cin ? r1[SEG] : r0[SEG];
endmodule

// File: rtl/csa_pipe.sv
// Pipelined carry-select adder with elastic valid/ready stages.
// Define CSA_PIPE_SUB_EN to add the op_sub input (a - b).
module csa_pipe import csa_pkg::*; #(
  parameter int WIDTH  = CSA_WIDTH,
  parameter int SEG    = CSA_SEG,
  parameter int STAGES = CSA_STAGES
) (
  input logic       clk,
  input logic       rst,
  csa_pipe_if.slave bus
);
  localparam int SL  = WIDTH / STAGES;
  localparam int SPS = SL / SEG;

  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;
  logic [STAGES-1:0] vld, load, v_src, c_src, stage_co;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [WIDTH-1:0]  s_src [STAGES];
  logic [WIDTH-1:0]  sum_n [STAGES];
  logic [WIDTH-1:0]  a_sk  [STAGES];
  logic [WIDTH-1:0]  b_sk  [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic              ovf_n, ovf_q;

`ifdef CSA_PIPE_SUB_EN
  assign b_eff   = bus.op_sub ? ~bus.b : bus.b;
  assign cin_eff = bus.op_sub ? 1'b1 : bus.c_in;
`else
  assign b_eff   = bus.b;
  assign cin_eff = bus.c_in;
`endif

  // Ready ripples back from the output; a stage loads when empty or draining.
  always_comb begin
    load = '0;
    load[STAGES-1] = !vld[STAGES-1] | bus.out_ready;
    for (int k = STAGES - 2; k >= 0; k--) load[k] = !vld[k] | load[k+1];
  end

  always_comb begin
    a_src[0] = bus.a;
    b_src[0] = b_eff;
    s_src[0] = '0;
    c_src[0] = cin_eff;
    v_src[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k] = a_sk[k-1];
      b_src[k] = b_sk[k-1];
      s_src[k] = sum_q[k-1];
      c_src[k] = c_q[k-1];
      v_src[k] = vld[k-1];
    end
  end

  // Operands and sum shift down by one slice per stage, so each stage always
  // works on bits [SL-1:0] of its source and the finished sum lands aligned.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [SL-1:0] ss;

    for (genvar j = 0; j < SPS; j++) begin : g_seg
      logic ci, co;
      if (j == 0) begin : g_c0
        assign ci = c_src[k];
      end else begin : g_cn
        assign ci = g_seg[j-1].co;
      end
      csa_seg #(.SEG(SEG)) u_seg (
        .a    (a_src[k][j*SEG +: SEG]),
        .b    (b_src[k][j*SEG +: SEG]),
        .cin  (ci),
        .sum  (ss[j*SEG +: SEG]),
        .cout (co)
      );
    end

    assign stage_co[k] = g_seg[SPS-1].co;
    assign sum_n[k]    = (s_src[k] >> SL) | (WIDTH'(ss) << (WIDTH - SL));

    if (k == STAGES - 1) begin : g_ovf
      assign ovf_n = a_src[k][SL-1] ^ b_src[k][SL-1] ^ ss[SL-1] ^ stage_co[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_sk[k]  <= '0;
        b_sk[k]  <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          vld[k]   <= v_src[k];
          c_q[k]   <= stage_co[k];
          sum_q[k] <= sum_n[k];
          a_sk[k]  <= a_src[k] >> SL;
          b_sk[k]  <= b_src[k] >> SL;
        end
      end
      if (load[STAGES-1]) ovf_q <= ovf_n;
    end
  end

  assign bus.in_ready  = load[0];
  assign bus.out_valid = vld[STAGES-1];
  assign bus.s         = sum_q[STAGES-1];
  assign bus.c_out     = c_q[STAGES-1];
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_csa_pipe.sv
// Directed bench for csa_pipe (32-bit, 8-bit segments, 2 stages).
// Exercises the subtract path too when CSA_PIPE_SUB_EN is defined.
module tb_csa_pipe;
  import csa_pkg::*;

  localparam int W   = 32;
  localparam int STG = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csa_pipe_if #(.WIDTH(W)) bus ();

  csa_pipe #(.WIDTH(W), .SEG(8), .STAGES(STG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] st_a [4] = '{32'd1,  32'd11,  32'd21,  32'd31};
  logic [31:0] st_b [4] = '{32'd0,  32'd100, 32'd200, 32'd300};
  logic        st_c [4] = '{1'b0,   1'b1,    1'b0,    1'b1};
  logic [31:0] st_s [4] = '{32'd1,  32'd112, 32'd221, 32'd332};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic ci);
    bus.in_valid = v;
    bus.a        = a;
    bus.b        = b;
    bus.c_in     = ci;
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic [31:0] es, input logic ec, input logic eo);
    int lat;
    drive(1'b1, a, b, ci);
    #1;
    check({tag, ".rdy"}, bus.in_ready, 1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, ".lat"}, lat, STG);
    check({tag, ".s"}, bus.s, es);
    check({tag, ".cout"}, bus.c_out, ec);
    check({tag, ".ovf"}, bus.ovf, eo);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rx, cyc;
    rst           = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0);
`ifdef CSA_PIPE_SUB_EN
    bus.op_sub = 1'b0;
`endif
    tick();
    rst = 1'b0;
    #1;
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.s", bus.s, 0);
    check("rst.cout", bus.c_out, 0);
    check("rst.ovf", bus.ovf, 0);
    check("rst.in_ready", bus.in_ready, 1);

    // Two back-to-back beats
    bus.out_ready = 1'b1;
    drive(1'b1, 32'd1200, 32'd9999, 1'b0);
    tick();
    check("b2b.early", bus.out_valid, 0);
    drive(1'b1, 32'd1000000, 32'd1231233, 1'b1);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    check("b2b.v0", bus.out_valid, 1);
    check("b2b.s0", bus.s, 32'd11199);
    check("b2b.c0", bus.c_out, 0);
    check("b2b.o0", bus.ovf, 0);
    tick();
    check("b2b.v1", bus.out_valid, 1);
    check("b2b.s1", bus.s, 32'd2231234);
    tick();
    check("b2b.idle", bus.out_valid, 0);

    run_one("carry_all", 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
    run_one("pos_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_one("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b1);
`ifdef CSA_PIPE_SUB_EN
    bus.op_sub = 1'b1;
    run_one("sub_neg", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_one("sub_pos", 32'd7, 32'd5, 1'b0, 32'd2, 1'b1, 1'b0);
    run_one("sub_ovf", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
    bus.op_sub = 1'b0;
`endif

    // Back-pressure: only STG beats fit, output held until out_ready rises
    bus.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, st_a[acc], st_b[acc], st_c[acc]);
      #1;
      if (bus.in_ready) acc++;
      tick();
    end
    check("stall.accepted", acc, STG);
    drive(1'b1, st_a[acc], st_b[acc], st_c[acc]);
    #1;
    check("stall.in_ready", bus.in_ready, 0);
    check("stall.out_valid", bus.out_valid, 1);
    check("stall.s", bus.s, st_s[0]);
    tick();
    tick();
    check("stall.hold_v", bus.out_valid, 1);
    check("stall.hold_s", bus.s, st_s[0]);
    check("stall.hold_c", bus.c_out, 0);

    bus.out_ready = 1'b1;
    rx  = 0;
    cyc = 0;
    while (rx < 4 && cyc < 30) begin
      if (acc < 4) drive(1'b1, st_a[acc], st_b[acc], st_c[acc]);
      else         drive(1'b0, 32'd0, 32'd0, 1'b0);
      #1;
      if (bus.out_valid) begin
        check($sformatf("order%0d", rx), bus.s, st_s[rx]);
        rx++;
      end
      if (bus.in_valid && bus.in_ready) acc++;
      tick();
      cyc++;
    end
    check("drain.received", rx, 4);
    check("drain.accepted", acc, 4);
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    check("drain.idle", bus.out_valid, 0);

    // Reset with two beats in flight
    bus.out_ready = 1'b0;
    drive(1'b1, 32'd100, 32'd200, 1'b0);
    tick();
    drive(1'b1, 32'd300, 32'd400, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("midrst.out_valid", bus.out_valid, 0);
    check("midrst.in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("midrst.stale%0d", c), bus.out_valid, 0);
    end
    run_one("post_rst", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
